// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b, LSB first, one full-subtractor cell.
// start/done handshake; result and flags are registered on completion
// and hold until the next completion or reset.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;     // operand shift registers, bit i sits at [0]
  logic [WIDTH-2:0] rsr;        // difference bits gathered so far
  logic             br;         // running borrow
  logic             d, br_nx, last;
  logic [WIDTH-1:0] full;       // complete difference on the final bit edge

  // Single full-subtractor cell plus the assembled result view
  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last  = (state == RUN) && (cnt == CW'(WIDTH-1));
    full  = {d, rsr};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; DONE always falls back to IDLE after one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, completion registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      rsr      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa   <= a;
          sb   <= b;
          br   <= 1'b0;
          cnt  <= '0;
          busy <= 1'b1;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nx;
          rsr <= full[WIDTH-1:1];
          cnt <= cnt + CW'(1);
          if (last) begin
            // sa[0]/sb[0] hold the operand MSBs on the final bit
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= full;
            borrow   <= br_nx;
            overflow <= (sa[0] ^ sb[0]) & (d ^ sa[0]);
            zero     <= ~|full;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub (WIDTH=4): directed vectors feed a scoreboard
// queue; a negedge monitor pops an entry on every done pulse.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, overflow, zero;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         br;
    logic         ov;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .borrow(borrow), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("result", int'(result), int'(e.res));
        check("borrow", int'(borrow), int'(e.br));
        check("overflow", int'(overflow), int'(e.ov));
        check("zero", int'(zero), int'(e.z));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after accept
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] er, input logic ebr,
                       input logic eov, input logic ez);
    exp_t e;
    e.res = er; e.br = ebr; e.ov = eov; e.z = ez;
    e.due = cyc + 1 + W;
    sb_q.push_back(e);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = 'x; b = 'x;
    check("busy_after_accept", int'(busy), 1);
  endtask

  // Wait for done (bounded), then one more cycle so the FSM is back in IDLE
  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_flags", int'({borrow, overflow, zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(4'b0110, 4'b0010, 4'b0100, 0, 0, 0); wait_done();
    issue(4'b0010, 4'b0110, 4'b1100, 1, 0, 0); wait_done();
    issue(4'b0100, 4'b1010, 4'b1010, 1, 1, 0); wait_done();
    issue(4'b1001, 4'b1001, 4'b0000, 0, 0, 1); wait_done();

    // Start pulsed during RUN must be dropped
    issue(4'b0111, 4'b0001, 4'b0110, 0, 0, 0);
    start = 1'b1; a = 4'b0000; b = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_mid", int'(busy), 1);
    @(negedge clk);
    check("busy_last", int'(busy), 1);
    @(negedge clk);
    check("busy_drop", int'(busy), 0);
    repeat (8) @(negedge clk);
    check("hold_result", int'(result), 6);
    check("idle_busy", int'(busy), 0);

    // Reset two cycles into RUN: outputs clear at once, no done pulse
    start = 1'b1; a = 4'b1111; b = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hold_during_run", int'(result), 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_flags", int'({borrow, overflow, zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    issue(4'b0101, 4'b0011, 4'b0010, 0, 0, 0); wait_done();
    repeat (4) @(negedge clk);
    check("pending", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
